// File: rtl/div_unit.sv
// div_unit: multi-cycle signed divider (MIPS div) using radix-2 restoring division.
// Quotient goes to lo, remainder to hi; a divide by zero leaves both untouched
// and raises the sticky div_zero flag instead.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // State register plus all datapath registers, cleared synchronously on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dvsr_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvsr_q     <= dvsr_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Next-state logic: a zero divisor skips straight to DONE, otherwise WIDTH CALC steps then FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch unsigned magnitudes, do one shift/subtract step per CALC cycle, re-apply signs in FIX.
  always_comb begin
    dvsr_d     = dvsr_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    div_zero_d = div_zero_q;

    // Magnitudes are WIDTH bits unsigned, so the most negative operand maps to 2^(WIDTH-1) exactly.
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = b[WIDTH-1] ? -b : b;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            div_zero_d = 1'b1;
          end else begin
            dvsr_d     = b_mag;
            quo_d      = a_mag;
            rem_d      = '0;
            cnt_d      = '0;
            neg_quo_d  = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d  = a[WIDTH-1];
            div_zero_d = 1'b0;
          end
        end
      end
      CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
      end
      FIX: begin
        lo_d = neg_quo_q ? -quo_q : quo_q;
        hi_d = neg_rem_q ? -rem_q : rem_q;
      end
      default: begin
      end
    endcase
  end

  // Outputs are decoded from registered state only, never from the inputs.
  always_comb begin
    busy     = (state_q == CALC) || (state_q == FIX);
    done     = (state_q == DONE);
    lo       = lo_q;
    hi       = hi_q;
    div_zero = div_zero_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against a
// plain-arithmetic reference using 64-bit truncating division.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        busy;
  logic        done;
  logic        div_zero;

  int tests_run;
  int tests_failed;

  // Last result the model believes is held in lo/hi.
  logic [31:0] exp_lo;
  logic [31:0] exp_hi;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .lo       (lo),
    .hi       (hi),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed division on 64-bit values, truncating toward zero.
  task automatic refDiv(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] q, output logic [31:0] r);
    longint la, lb;
    logic [63:0] tq, tr;
    la = longint'($signed(av));
    lb = longint'($signed(bv));
    tq = la / lb;
    tr = la % lb;
    q  = tq[31:0];
    r  = tr[31:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one start pulse, scramble operands afterwards, wait (bounded) for done.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               output int lat, output int busy_cycles);
    start = 1'b1;
    a     = av;
    b     = bv;
    lat   = 0;
    busy_cycles = 0;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    lat   = 1;
    while (!done && lat < 60) begin
      if (busy) busy_cycles++;
      tick();
      lat++;
    end
    if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
    tick();
  endtask

  // Run one division and compare every output with the model.
  task automatic runChecked(input string tag, input logic [31:0] av, input logic [31:0] bv);
    int lat, bcy;
    logic [31:0] q, r;
    applyStimulus(av, bv, lat, bcy);
    if (bv == 32'd0) begin
      checkOutput({tag, "_lat"}, 64'(lat), 64'd1);
      checkOutput({tag, "_dz"}, {63'd0, div_zero}, 64'd1);
      checkOutput({tag, "_busy"}, 64'(bcy), 64'd0);
    end else begin
      refDiv(av, bv, q, r);
      exp_lo = q;
      exp_hi = r;
      checkOutput({tag, "_lat"}, 64'(lat), 64'd34);
      checkOutput({tag, "_dz"}, {63'd0, div_zero}, 64'd0);
    end
    checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
  endtask

  function automatic logic [31:0] pickOperand(input int kind);
    logic [31:0] v;
    case (kind)
      0: v = $urandom;
      1: v = 32'($signed($urandom_range(0, 40)) - 20);
      2: begin
        case ($urandom_range(0, 3))
          0: v = 32'h8000_0000;
          1: v = 32'hFFFF_FFFF;
          2: v = 32'h7FFF_FFFF;
          default: v = 32'h0000_0001;
        endcase
      end
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  initial begin
    int lat, bcy, done_count, done_cycle;
    logic [31:0] ra, rb;

    tests_run    = 0;
    tests_failed = 0;
    exp_lo = '0;
    exp_hi = '0;
    reset  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    tick();
    tick();
    reset = 1'b0;

    checkOutput("rst_lo", 64'(lo), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_dz", {63'd0, div_zero}, 64'd0);

    // Positive operands, with the busy window length.
    applyStimulus(32'd7, 32'd2, lat, bcy);
    checkOutput("pos_lat", 64'(lat), 64'd34);
    checkOutput("pos_busy", 64'(bcy), 64'd33);
    checkOutput("pos_lo", 64'(lo), 64'd3);
    checkOutput("pos_hi", 64'(hi), 64'd1);
    checkOutput("pos_dz", {63'd0, div_zero}, 64'd0);
    exp_lo = 32'd3;
    exp_hi = 32'd1;

    // Divide by zero keeps the previous result and raises the flag.
    runChecked("dz", 32'd5, 32'd0);
    checkOutput("dz_lo_kept", 64'(lo), 64'd3);
    checkOutput("dz_hi_kept", 64'(hi), 64'd1);

    // Signed cases; the first also clears div_zero.
    runChecked("negdvd", 32'hFFFF_FFF9, 32'd2);
    checkOutput("negdvd_lo_c", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("negdvd_hi_c", 64'(hi), 64'hFFFF_FFFF);
    runChecked("negdvs", 32'd7, 32'hFFFF_FFFE);
    checkOutput("negdvs_lo_c", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("negdvs_hi_c", 64'(hi), 64'd1);

    // Most negative dividend.
    runChecked("ovf_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("ovf_m1_lo_c", 64'(lo), 64'h8000_0000);
    checkOutput("ovf_m1_hi_c", 64'(hi), 64'd0);
    runChecked("ovf_p1", 32'h8000_0000, 32'd1);
    checkOutput("ovf_p1_lo_c", 64'(lo), 64'h8000_0000);

    // Second start while busy must be ignored.
    start = 1'b1;
    a = 32'd100;
    b = 32'd7;
    done_count = 0;
    done_cycle = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      start = (cyc == 9);
      a = 32'd1;
      b = 32'd1;
      if (done) begin
        done_count++;
        done_cycle = cyc;
        checkOutput("sbusy_lo", 64'(lo), 64'd14);
        checkOutput("sbusy_hi", 64'(hi), 64'd2);
      end
    end
    start = 1'b0;
    checkOutput("sbusy_done_count", 64'(done_count), 64'd1);
    checkOutput("sbusy_done_cycle", 64'(done_cycle), 64'd34);

    // Reset in the middle of a division.
    start = 1'b1;
    a = 32'd100;
    b = 32'd7;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 15; cyc++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mrst_lo", 64'(lo), 64'd0);
    checkOutput("mrst_hi", 64'(hi), 64'd0);
    checkOutput("mrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("mrst_done", {63'd0, done}, 64'd0);
    checkOutput("mrst_dz", {63'd0, div_zero}, 64'd0);
    done_count = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) done_count++;
      tick();
    end
    checkOutput("mrst_no_done", 64'(done_count), 64'd0);
    exp_lo = '0;
    exp_hi = '0;
    runChecked("mrst_fresh", 32'hFFFF_FFF7, 32'hFFFF_FFFC);
    checkOutput("mrst_fresh_lo_c", 64'(lo), 64'd2);
    checkOutput("mrst_fresh_hi_c", 64'(hi), 64'hFFFF_FFFF);

    // Randomized regression, with an occasional zero divisor.
    for (int i = 0; i < 1500; i++) begin
      ra = pickOperand($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        rb = 32'd0;
      end else begin
        rb = pickOperand($urandom_range(0, 3));
        if (rb == 32'd0) rb = 32'd3;
      end
      runChecked("rand", ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
